// File: rtl/sdo_frame_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdo_frame_receiver_if
//  Description : Serial-in / parallel-out bundle for sdo_frame_receiver.
//                master = serial source + word consumer (testbench side),
//                slave  = the receiver itself.
//  Signals     : SDI       serial line in, idle high
//                RX_READY  consumer accepts RX_DATA while RX_VALID is high
//                RX_DATA   last received word, MSB = first data bit on line
//                RX_VALID  RX_DATA holds an unconsumed word
//                FRAME_ERR one-cycle pulse, stop bit sampled low
//                OVERRUN   one-cycle pulse, completed word dropped
//                BUSY      receiver is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
interface sdo_frame_receiver_if #(
  parameter int DATA_W = 16
) ();
  logic              SDI;
  logic              RX_READY;
  logic [DATA_W-1:0] RX_DATA;
  logic              RX_VALID;
  logic              FRAME_ERR;
  logic              OVERRUN;
  logic              BUSY;

  modport master (
    output SDI,
    output RX_READY,
    input  RX_DATA,
    input  RX_VALID,
    input  FRAME_ERR,
    input  OVERRUN,
    input  BUSY
  );

  modport slave (
    input  SDI,
    input  RX_READY,
    output RX_DATA,
    output RX_VALID,
    output FRAME_ERR,
    output OVERRUN,
    output BUSY
  );
endinterface
`default_nettype wire

// File: rtl/sdo_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : sdo_frame_receiver
//  Description : Oversampling receiver for the SDO serial stream. Frames are
//                idle-high, one start bit (0), DATA_W data bits MSB first,
//                one stop bit (1), CLKS_PER_BIT clocks per bit. Completed
//                words are offered on a valid/ready holding register with
//                framing-error and overrun pulses.
//  Ports       : CLK  - receiver clock
//                RST  - asynchronous active-high reset
//                bus  - sdo_frame_receiver_if.slave (SDI, RX_READY in;
//                       RX_DATA, RX_VALID, FRAME_ERR, OVERRUN, BUSY out)
//  Revision    : 1.0 - initial release
// ============================================================================
module sdo_frame_receiver #(
  parameter int DATA_W       = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input  wire logic            CLK,
  input  wire logic            RST,
  sdo_frame_receiver_if.slave  bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] c_cnt_mid  = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_sdi_meta;
  logic                r_sdi_s;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_shreg;
  logic [DATA_W-1:0]   r_rx_data;
  logic                r_rx_valid;
  logic                r_frame_err;
  logic                r_overrun;

  logic                w_cnt_inc;
  logic                w_cnt_clr;
  logic                w_idx_clr;
  logic                w_shift;
  logic                w_stop_ok;
  logic                w_stop_bad;
  logic                w_accept;

  // Two-flop synchronizer; idle level is high so reset to 1 to avoid a
  // spurious start detection right after reset release.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sdi_meta <= 1'b1;
      r_sdi_s    <= 1'b1;
    end else begin
      r_sdi_meta <= bus.SDI;
      r_sdi_s    <= r_sdi_meta;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_inc   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_idx_clr   = 1'b0;
    w_shift     = 1'b0;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
        if (!r_sdi_s) w_state_nxt = START;
      end
      START: begin
        // Re-check the line half a bit in; a high here was a glitch.
        if (r_cnt == c_cnt_mid) begin
          w_cnt_clr   = 1'b1;
          w_idx_clr   = 1'b1;
          w_state_nxt = r_sdi_s ? IDLE : DATA;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      DATA: begin
        if (r_cnt == c_cnt_last) begin
          w_cnt_clr = 1'b1;
          w_shift   = 1'b1;
          if (r_idx == c_idx_last) w_state_nxt = STOP;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      STOP: begin
        // Returning to IDLE on the sample cycle (mid stop bit) leaves half a
        // bit of margin to catch an immediately following start bit.
        if (r_cnt == c_cnt_last) begin
          w_cnt_clr = 1'b1;
          if (r_sdi_s) begin
            w_stop_ok   = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_stop_bad  = 1'b1;
            w_state_nxt = WAIT_HIGH;
          end
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      WAIT_HIGH: begin
        // A line stuck low must not be mistaken for the next start bit.
        if (r_sdi_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bit timing counter, bit index and shift register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shreg <= '0;
    end else begin
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);

      if (w_idx_clr)      r_idx <= '0;
      else if (w_shift)   r_idx <= r_idx + IDX_W'(1);

      if (w_shift) r_shreg <= {r_shreg[DATA_W-2:0], r_sdi_s};
    end
  end

  // Holding register can take a new word when empty or being drained now.
  assign w_accept = !r_rx_valid || bus.RX_READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      r_overrun   <= w_stop_ok && !w_accept;
      if (w_stop_ok && w_accept) begin
        r_rx_data  <= r_shreg;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && bus.RX_READY) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign bus.RX_DATA   = r_rx_data;
  assign bus.RX_VALID  = r_rx_valid;
  assign bus.FRAME_ERR = r_frame_err;
  assign bus.OVERRUN   = r_overrun;
  assign bus.BUSY      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sdo_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdo_frame_receiver
//  Description : Directed self-checking bench for sdo_frame_receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdo_frame_receiver;

  localparam int DW  = 16;
  localparam int CPB = 4;

  logic CLK;
  logic RST;

  sdo_frame_receiver_if #(.DATA_W(DW)) bus ();

  sdo_frame_receiver #(
    .DATA_W       (DW),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge (inputs change just after the
  // rising edge, so RX_READY seen here is what the next rising edge uses).
  logic [DW-1:0] acc[$];
  int            ferr_n   = 0;
  int            ovr_n    = 0;
  int            vcyc_n   = 0;
  int            unstable = 0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge CLK) begin
    if (bus.RX_VALID && bus.RX_READY) acc.push_back(bus.RX_DATA);
    if (bus.FRAME_ERR) ferr_n++;
    if (bus.OVERRUN)   ovr_n++;
    if (bus.RX_VALID)  vcyc_n++;
    if (prev_hold && bus.RX_VALID && (bus.RX_DATA !== prev_data)) unstable++;
    prev_hold = bus.RX_VALID && !bus.RX_READY;
    prev_data = bus.RX_DATA;
  end

  task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit);
    logic [DW+1:0] bits;
    bits = {1'b0, d, stop_bit};
    for (int i = DW + 1; i >= 0; i--) begin
      repeat (CPB) begin
        @(posedge CLK);
        #1;
        bus.SDI = bits[i];
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  int f0, o0, v0, a0;

  task automatic snap();
    f0 = ferr_n;
    o0 = ovr_n;
    v0 = vcyc_n;
    a0 = acc.size();
  endtask

  initial begin
    RST          = 1'b1;
    bus.SDI      = 1'b1;
    bus.RX_READY = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_data",  32'(bus.RX_DATA),   32'h0);
    chk("rst_valid", 32'(bus.RX_VALID),  32'h0);
    chk("rst_ferr",  32'(bus.FRAME_ERR), 32'h0);
    chk("rst_ovr",   32'(bus.OVERRUN),   32'h0);
    chk("rst_busy",  32'(bus.BUSY),      32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idle(4);

    // Single frame, consumer always ready: valid for exactly one cycle
    bus.RX_READY = 1'b1;
    snap();
    send_frame(16'hA5C3, 1'b1);
    idle(8);
    chk("t1_cnt",   32'(acc.size() - a0), 32'd1);
    chk("t1_data",  32'(acc[$]),          32'hA5C3);
    chk("t1_vcyc",  32'(vcyc_n - v0),     32'd1);
    chk("t1_ferr",  32'(ferr_n - f0),     32'd0);
    chk("t1_ovr",   32'(ovr_n - o0),      32'd0);
    chk("t1_busy",  32'(bus.BUSY),        32'd0);

    // One-cycle glitch on an idle line
    snap();
    @(posedge CLK); #1; bus.SDI = 1'b0;
    @(posedge CLK); #1; bus.SDI = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    chk("t2_busy_hi", 32'(bus.BUSY), 32'd1);
    repeat (CPB) @(negedge CLK);
    chk("t2_busy_lo", 32'(bus.BUSY),        32'd0);
    chk("t2_vcyc",    32'(vcyc_n - v0),     32'd0);
    chk("t2_ferr",    32'(ferr_n - f0),     32'd0);
    idle(4);

    // Framing error, line held low, then a good frame
    bus.RX_READY = 1'b0;
    snap();
    send_frame(16'h00FF, 1'b0);
    idle(20);
    bus.SDI = 1'b1;
    idle(4);
    send_frame(16'h0001, 1'b1);
    idle(8);
    chk("t3_ferr",  32'(ferr_n - f0),  32'd1);
    chk("t3_ovr",   32'(ovr_n - o0),   32'd0);
    chk("t3_valid", 32'(bus.RX_VALID), 32'd1);
    chk("t3_data",  32'(bus.RX_DATA),  32'h0001);
    bus.RX_READY = 1'b1;
    idle(2);
    chk("t3_acc",   32'(acc[$]),       32'h0001);
    chk("t3_cnt",   32'(acc.size() - a0), 32'd1);

    // Back-to-back frames with consumer stalled: second word overruns
    bus.RX_READY = 1'b0;
    idle(2);
    snap();
    send_frame(16'h1234, 1'b1);
    send_frame(16'h5678, 1'b1);
    idle(8);
    chk("t4_data",  32'(bus.RX_DATA),  32'h1234);
    chk("t4_valid", 32'(bus.RX_VALID), 32'd1);
    chk("t4_ovr",   32'(ovr_n - o0),   32'd1);
    chk("t4_ferr",  32'(ferr_n - f0),  32'd0);
    @(posedge CLK); #1; bus.RX_READY = 1'b1;
    @(negedge CLK);
    chk("t4_valid_hold", 32'(bus.RX_VALID), 32'd1);
    @(negedge CLK);
    chk("t4_valid_drop", 32'(bus.RX_VALID), 32'd0);
    chk("t4_acc",   32'(acc[$]),       32'h1234);
    @(posedge CLK); #1; bus.RX_READY = 1'b0;
    idle(2);

    // Ready asserted exactly on the second delivery edge (145 edges after the
    // first drive edge of the first frame): refill in place, no overrun.
    snap();
    fork
      begin
        send_frame(16'hBEEF, 1'b1);
        send_frame(16'hCAFE, 1'b1);
      end
      begin
        repeat (145) @(posedge CLK);
        #1;
        bus.RX_READY = 1'b1;
        @(posedge CLK);
        #1;
        bus.RX_READY = 1'b0;
      end
    join
    idle(8);
    chk("t5_ovr",   32'(ovr_n - o0),   32'd0);
    chk("t5_valid", 32'(bus.RX_VALID), 32'd1);
    chk("t5_data",  32'(bus.RX_DATA),  32'hCAFE);
    chk("t5_acc",   32'(acc[$]),       32'hBEEF);
    bus.RX_READY = 1'b1;
    idle(3);
    chk("t5_drain", 32'(acc[$]),       32'hCAFE);

    // Reset in the middle of data bit 7, then a clean frame
    snap();
    fork
      send_frame(16'hFFFF, 1'b1);
      begin
        repeat (35) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(negedge CLK);
        chk("t6_rst_data",  32'(bus.RX_DATA),   32'h0);
        chk("t6_rst_valid", 32'(bus.RX_VALID),  32'h0);
        chk("t6_rst_ferr",  32'(bus.FRAME_ERR), 32'h0);
        chk("t6_rst_ovr",   32'(bus.OVERRUN),   32'h0);
        chk("t6_rst_busy",  32'(bus.BUSY),      32'h0);
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
      end
    join
    idle(4);
    send_frame(16'h8001, 1'b1);
    idle(8);
    chk("t6_cnt",   32'(acc.size() - a0), 32'd1);
    chk("t6_data",  32'(acc[$]),          32'h8001);
    chk("t6_ferr",  32'(ferr_n - f0),     32'd0);
    chk("t6_ovr",   32'(ovr_n - o0),      32'd0);

    chk("stable", 32'(unstable), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
